// File: rtl/player_pkg.sv
// Shared types and default timing constants for the player life-cycle logic.
package player_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAYING   = 3'd1,
        EXPLODING = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4
    } player_state_t;

    // Defaults, also used by the sprite drawer so animations stay in step.
    localparam int DEF_EXPLODE_FRAMES = 32;
    localparam int DEF_INVULN_FRAMES  = 120;
    localparam int DEF_BLINK_FRAMES   = 8;

    // Bits needed to hold max(a, b) - 1, never less than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/player_life_ctrl_frame_timer.sv
// Counts startOfFrame pulses up to N-1; done flags the last frame in the
// same cycle as its startOfFrame pulse.
module frame_timer #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         sof_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q, count_d;

    assign done_o  = sof_i && (count_q == W'(N - 1));
    assign count_o = count_q;

    // Next count: clear wins, otherwise advance per frame and wrap after N-1.
    always_comb begin
        count_d = count_q;
        if (clear_i)     count_d = '0;
        else if (done_o) count_d = '0;
        else if (sof_i)  count_d = count_q + W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/player_life_ctrl.sv
// Player life-cycle FSM: hit -> explosion -> respawn/invulnerability or
// game over, with registered pulse and level outputs.
module player_life_ctrl
    import player_pkg::*;
#(
    parameter int EXPLODE_FRAMES = DEF_EXPLODE_FRAMES,
    parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES,
    parameter int BLINK_FRAMES   = DEF_BLINK_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       startOfFrame,
    input  logic [2:0] lives_left,
    output logic       explosion,
    output logic       game_over,
    output logic       new_game,
    output logic       respawn,
    output logic       exploding,
    output logic       invulnerable,
    output logic       player_visible
);

    localparam int CNT_W = cnt_width(EXPLODE_FRAMES, INVULN_FRAMES);

    player_state_t state_q, state_d;
    logic          state_chg;
    logic [CNT_W-1:0] exp_cnt, inv_cnt, frame_cnt, frame_cnt_nx;
    logic          exp_done, inv_done;
    logic          explosion_d, new_game_d, respawn_d, visible_d;
    logic          explosion_q, game_over_q, new_game_q, respawn_q;
    logic          exploding_q, invulnerable_q, visible_q;

    // Every state change restarts the frame count at 0.
    assign state_chg = (state_d != state_q);

    frame_timer #(.N(EXPLODE_FRAMES), .W(CNT_W)) u_exp_tmr (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_chg),
        .sof_i   (startOfFrame),
        .count_o (exp_cnt),
        .done_o  (exp_done)
    );

    frame_timer #(.N(INVULN_FRAMES), .W(CNT_W)) u_inv_tmr (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_chg),
        .sof_i   (startOfFrame),
        .count_o (inv_cnt),
        .done_o  (inv_done)
    );

    // The registered visibility needs the count as it will be after this edge.
    assign frame_cnt    = (state_q == RESPAWN) ? inv_cnt : exp_cnt;
    assign frame_cnt_nx = state_chg    ? '0 :
                          startOfFrame ? frame_cnt + CNT_W'(1) : frame_cnt;

    // Next state and one-cycle pulse requests.
    always_comb begin
        state_d     = state_q;
        explosion_d = 1'b0;
        new_game_d  = 1'b0;
        respawn_d   = 1'b0;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start) begin
                    new_game_d = 1'b1;
                    state_d    = PLAYING;
                end
            end
            PLAYING: begin
                if (hit) begin
                    explosion_d = 1'b1;
                    state_d     = EXPLODING;
                end else if (lives_left == 3'd0 && !new_game_q) begin
                    // While new_game is on the wire the lives counter has not
                    // reloaded yet, so a zero here is stale.
                    state_d = GAME_OVER;
                end
            end
            EXPLODING: begin
                if (exp_done) begin
                    if (lives_left == 3'd0) begin
                        state_d = GAME_OVER;
                    end else begin
                        respawn_d = 1'b1;
                        state_d   = RESPAWN;
                    end
                end
            end
            RESPAWN: begin
                if (inv_done) state_d = PLAYING;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sprite enable: solid while playing, blinking during invulnerability.
    always_comb begin
        visible_d = 1'b0;
        if (state_d == PLAYING)
            visible_d = 1'b1;
        else if (state_d == RESPAWN)
            visible_d = ((frame_cnt_nx & CNT_W'(BLINK_FRAMES)) == '0);
    end

    // State and output registers; reset drops any in-flight pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            explosion_q    <= 1'b0;
            game_over_q    <= 1'b0;
            new_game_q     <= 1'b0;
            respawn_q      <= 1'b0;
            exploding_q    <= 1'b0;
            invulnerable_q <= 1'b0;
            visible_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            explosion_q    <= explosion_d;
            game_over_q    <= (state_d == GAME_OVER);
            new_game_q     <= new_game_d;
            respawn_q      <= respawn_d;
            exploding_q    <= (state_d == EXPLODING);
            invulnerable_q <= (state_d == RESPAWN);
            visible_q      <= visible_d;
        end
    end

    assign explosion      = explosion_q;
    assign game_over      = game_over_q;
    assign new_game       = new_game_q;
    assign respawn        = respawn_q;
    assign exploding      = exploding_q;
    assign invulnerable   = invulnerable_q;
    assign player_visible = visible_q;

endmodule
